hdmi_link_ctrl: RTL and testbench

Link bring-up and source-select controller for the HDMI pass-through path, running in the clk25 domain. It watches the receive decoder's lock, channel-ready and phase-alignment status, and sequences the decoder reset and the transmit PLL reset. It declares the link up only after the receive side has been continuously stable, and switches the output source between live video and test pattern only on a frame boundary. It retries failed bring-ups and counts errors.

---
 rtl/hdmi_link_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hdmi_link_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_link_ctrl.sv
// HDMI pass-through link bring-up FSM: sequences decoder and TX PLL resets,
// qualifies receive stability and switches video source on frame boundaries.
module hdmi_link_ctrl #(
  parameter int RX_RST_CYCLES = 16,
  parameter int LOCK_WAIT     = 250000,
  parameter int STABLE_CYCLES = 2500,
  parameter int TX_RST_CYCLES = 64,
  parameter int VSYNC_TIMEOUT = 1250000
) (
  input  logic       clk25,
  input  logic       rstin,
  input  logic       rx_plllckd,
  input  logic [2:0] rx_rdy,
  input  logic       rx_psalgnerr,
  input  logic       rx_vsync,
  input  logic       tx_lock,
  input  logic       force_pattern,
  output logic       rx_exrst,
  output logic       tx_pll_reset,
  output logic       src_sel,
  output logic       link_up,
  output logic [2:0] state,
  output logic [7:0] err_count
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CMAX = imax(imax(RX_RST_CYCLES, LOCK_WAIT), imax(STABLE_CYCLES, TX_RST_CYCLES));
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = $clog2(VSYNC_TIMEOUT + 1);

  localparam logic [CW-1:0] RXR_LAST = CW'(RX_RST_CYCLES - 1);
  localparam logic [CW-1:0] LW_LAST  = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TXR_LAST = CW'(TX_RST_CYCLES - 1);
  localparam logic [PW-1:0] PT_LAST  = PW'(VSYNC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RXRST  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_TXRST  = 3'd3,
    S_TXWAIT = 3'd4,
    S_RUN    = 3'd5
  } st_t;

  // Synchronizers; index [1] is the synchronized value, vsync keeps one more tap
  logic [1:0]      lock_sy, algn_sy, txl_sy, frc_sy;
  logic [1:0][2:0] rdy_sy;
  logic [2:0]      vs_sy;

  always_ff @(posedge clk25 or posedge rstin) begin
    if (rstin) begin
      lock_sy <= '0;
      algn_sy <= '0;
      txl_sy  <= '0;
      frc_sy  <= '0;
      rdy_sy  <= '0;
      vs_sy   <= '0;
    end else begin
      lock_sy <= {lock_sy[0], rx_plllckd};
      algn_sy <= {algn_sy[0], rx_psalgnerr};
      txl_sy  <= {txl_sy[0], tx_lock};
      frc_sy  <= {frc_sy[0], force_pattern};
      rdy_sy  <= {rdy_sy[0], rx_rdy};
      vs_sy   <= {vs_sy[1:0], rx_vsync};
    end
  end

  logic good, txl_s, desired, vs_rise;
  assign good    = lock_sy[1] & (&rdy_sy[1]) & ~algn_sy[1];
  assign txl_s   = txl_sy[1];
  assign desired = ~frc_sy[1];
  assign vs_rise = vs_sy[1] & ~vs_sy[2];

  st_t           cur, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_inc;

  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    err_inc = 1'b0;
    case (cur)
      S_RXRST: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == RXR_LAST) nxt = S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = cnt + 1'b1;
        if (good) nxt = S_STABLE;
        else if (cnt == LW_LAST) begin
          nxt     = S_RXRST;
          err_inc = 1'b1;
        end
      end
      S_STABLE: begin
        cnt_nxt = cnt + 1'b1;
        if (!good) nxt = S_WAIT;
        else if (cnt == ST_LAST) nxt = S_TXRST;
      end
      S_TXRST: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == TXR_LAST) nxt = S_TXWAIT;
      end
      S_TXWAIT: begin
        cnt_nxt = cnt + 1'b1;
        if (!good) begin
          nxt     = S_RXRST;
          err_inc = 1'b1;
        end else if (txl_s) nxt = S_RUN;
        else if (cnt == LW_LAST) begin
          nxt     = S_TXRST;
          err_inc = 1'b1;
        end
      end
      S_RUN: begin
        // RX loss outranks TX loss so a combined fault restarts from the decoder
        if (!good) begin
          nxt     = S_RXRST;
          err_inc = 1'b1;
        end else if (!txl_s) begin
          nxt     = S_TXRST;
          err_inc = 1'b1;
        end
      end
      default: nxt = S_RXRST;
    endcase
    if (nxt != cur) cnt_nxt = '0;
  end

  always_ff @(posedge clk25 or posedge rstin) begin
    if (rstin) begin
      cur          <= S_RXRST;
      cnt          <= '0;
      rx_exrst     <= 1'b1;
      tx_pll_reset <= 1'b1;
      link_up      <= 1'b0;
      err_count    <= '0;
    end else begin
      cur          <= nxt;
      cnt          <= cnt_nxt;
      rx_exrst     <= (nxt == S_RXRST);
      tx_pll_reset <= (nxt == S_RXRST) || (nxt == S_WAIT) ||
                      (nxt == S_STABLE) || (nxt == S_TXRST);
      link_up      <= (nxt == S_RUN);
      if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  assign state = cur;

  // Source select: only moves inside RUN, restarts at test pattern on each entry
  logic [PW-1:0] pend_cnt;

  always_ff @(posedge clk25 or posedge rstin) begin
    if (rstin) begin
      src_sel  <= 1'b0;
      pend_cnt <= '0;
    end else if ((nxt != S_RUN) || (cur != S_RUN)) begin
      src_sel  <= 1'b0;
      pend_cnt <= '0;
    end else if (desired == src_sel) begin
      pend_cnt <= '0;
    end else if (vs_rise || (pend_cnt == PT_LAST)) begin
      src_sel  <= desired;
      pend_cnt <= '0;
    end else begin
      pend_cnt <= pend_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hdmi_link_ctrl.sv
// Bench for hdmi_link_ctrl: bring-up, fault table, source switching against
// a cycle-history model, glitch, lock timeout, saturation and async reset.
module tb_hdmi_link_ctrl;
  localparam int RXR = 4, LW = 100, STC = 20, TXR = 8, VT = 200;

  logic       clk25 = 1'b0, rstin = 1'b1;
  logic       rx_plllckd = 1'b1, rx_psalgnerr = 1'b0, rx_vsync = 1'b0;
  logic       tx_lock = 1'b1, force_pattern = 1'b0;
  logic [2:0] rx_rdy = 3'b111;
  logic       rx_exrst, tx_pll_reset, src_sel, link_up;
  logic [2:0] state;
  logic [7:0] err_count;

  hdmi_link_ctrl #(.RX_RST_CYCLES(RXR), .LOCK_WAIT(LW), .STABLE_CYCLES(STC),
                   .TX_RST_CYCLES(TXR), .VSYNC_TIMEOUT(VT)) dut (
    .clk25(clk25), .rstin(rstin), .rx_plllckd(rx_plllckd), .rx_rdy(rx_rdy),
    .rx_psalgnerr(rx_psalgnerr), .rx_vsync(rx_vsync), .tx_lock(tx_lock),
    .force_pattern(force_pattern), .rx_exrst(rx_exrst), .tx_pll_reset(tx_pll_reset),
    .src_sel(src_sel), .link_up(link_up), .state(state), .err_count(err_count));

  always #20 clk25 = ~clk25;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(negedge clk25);
  endtask

  task automatic set_good();
    rx_plllckd = 1'b1; rx_rdy = 3'b111; rx_psalgnerr = 1'b0; tx_lock = 1'b1;
  endtask

  task automatic do_reset();
    rstin = 1'b1;
    set_good();
    force_pattern = 1'b0; rx_vsync = 1'b0;
    repeat (3) step();
    rstin = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget, input string nm);
    int i;
    i = 0;
    while (int'(state) != s && i < budget) begin
      step();
      i++;
    end
    chk(nm, int'(state), s);
  endtask

  // Fault table: inputs applied from RUN and the state expected 3 cycles later
  typedef struct {
    logic       lck;
    logic [2:0] rdy;
    logic       algn;
    logic       txl;
    int         exp_state;
  } fvec_t;
  fvec_t fv[6];

  logic fq[$], vq[$];
  logic msrc, f, v, des, rise, stay;
  int   age, exp_err, nstab, nr, nlu;
  int   rises[$];
  int   seq[$];
  logic prev_exrst;

  initial begin
    fv[0] = '{1'b0, 3'b111, 1'b0, 1'b1, 0};
    fv[1] = '{1'b1, 3'b110, 1'b0, 1'b1, 0};
    fv[2] = '{1'b1, 3'b111, 1'b1, 1'b1, 0};
    fv[3] = '{1'b1, 3'b111, 1'b0, 1'b0, 3};
    fv[4] = '{1'b0, 3'b111, 1'b0, 1'b0, 0};
    fv[5] = '{1'b1, 3'b011, 1'b0, 1'b1, 0};

    // Reset values
    repeat (2) step();
    chk("rst_state", int'(state), 0);
    chk("rst_exrst", int'(rx_exrst), 1);
    chk("rst_txrst", int'(tx_pll_reset), 1);
    chk("rst_src", int'(src_sel), 0);
    chk("rst_link", int'(link_up), 0);
    chk("rst_err", int'(err_count), 0);

    // Clean bring-up
    do_reset();
    seq.push_back(int'(state));
    for (int i = 1; i <= 100; i++) begin
      step();
      if (i <= RXR) chk($sformatf("exrst_edge%0d", i), int'(rx_exrst), (i < RXR) ? 1 : 0);
      if (int'(state) != seq[$]) seq.push_back(int'(state));
      if (state == 3'd5) break;
    end
    chk("bringup_len", seq.size(), 6);
    foreach (seq[j]) chk($sformatf("bringup_seq%0d", j), seq[j], j);
    chk("run_link", int'(link_up), 1);
    chk("run_src0", int'(src_sel), 0);
    chk("run_txrst", int'(tx_pll_reset), 0);
    chk("run_err", int'(err_count), 0);

    // First vsync edge after RUN entry selects live video
    rx_vsync = 1'b1;
    step(); step();
    chk("vs_before", int'(src_sel), 0);
    rx_vsync = 1'b0;
    step();
    chk("vs_switch", int'(src_sel), 1);

    // Timeout-forced switch to pattern
    repeat (5) step();
    force_pattern = 1'b1;
    repeat (195) step();
    chk("to_early", int'(src_sel), 1);
    repeat (15) step();
    chk("to_forced", int'(src_sel), 0);

    // Back to live on a vsync edge at cycle 50
    force_pattern = 1'b0;
    repeat (50) step();
    chk("vs50_before", int'(src_sel), 0);
    rx_vsync = 1'b1;
    step(); step();
    rx_vsync = 1'b0;
    step();
    chk("vs50_switch", int'(src_sel), 1);

    // Toggle and revert without vsync: no change
    repeat (5) step();
    force_pattern = 1'b1;
    repeat (30) step();
    force_pattern = 1'b0;
    stay = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (src_sel !== 1'b1) stay = 1'b0;
    end
    chk("revert_nochange", int'(stay), 1);

    // Randomized switching in RUN against a history-based model
    msrc = 1'b1; age = 0; f = 1'b0; v = 1'b0;
    fq = {1'b0, 1'b0, 1'b0};
    vq = {1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 89) == 0) f = ~f;
      if ($urandom_range(0, 149) == 0) v = ~v;
      force_pattern = f; rx_vsync = v;
      fq.push_back(f); vq.push_back(v);
      @(posedge clk25);
      des  = ~fq[fq.size()-3];
      rise = vq[vq.size()-3] & ~vq[vq.size()-4];
      if (des == msrc) age = 0;
      else begin
        age++;
        if (rise || age >= VT) begin
          msrc = des;
          age = 0;
        end
      end
      step();
      chk($sformatf("rand_src%0d", k), int'(src_sel), int'(msrc));
    end
    force_pattern = 1'b0; rx_vsync = 1'b0;

    // Fault table from RUN
    exp_err = 0;
    for (int i = 0; i < 6; i++) begin
      wait_state(5, 400, $sformatf("f%0d_inrun", i));
      rx_plllckd = fv[i].lck; rx_rdy = fv[i].rdy;
      rx_psalgnerr = fv[i].algn; tx_lock = fv[i].txl;
      step(); step();
      chk($sformatf("f%0d_link_hold", i), int'(link_up), 1);
      step();
      chk($sformatf("f%0d_state", i), int'(state), fv[i].exp_state);
      chk($sformatf("f%0d_link", i), int'(link_up), 0);
      chk($sformatf("f%0d_src", i), int'(src_sel), 0);
      chk($sformatf("f%0d_txrst", i), int'(tx_pll_reset), 1);
      exp_err++;
      chk($sformatf("f%0d_err", i), int'(err_count), exp_err);
      set_good();
    end
    wait_state(5, 400, "f_recover");

    // Glitch during STABLE restarts the stability window
    do_reset();
    wait_state(2, 50, "gl_stable");
    repeat (15) step();
    rx_rdy = 3'b101;
    step();
    rx_rdy = 3'b111;
    wait_state(1, 5, "gl_wait");
    wait_state(2, 5, "gl_restable");
    nstab = 0;
    while (state == 3'd2 && nstab < 60) begin
      nstab++;
      step();
    end
    chk("gl_len", nstab, STC);
    chk("gl_next", int'(state), 3);
    chk("gl_err", int'(err_count), 0);

    // No RX lock for 350 cycles
    do_reset();
    rstin = 1'b1;
    rx_plllckd = 1'b0;
    step();
    rstin = 1'b0;
    prev_exrst = rx_exrst;
    nlu = 0;
    rises.delete();
    for (int i = 1; i <= 350; i++) begin
      step();
      if (rx_exrst && !prev_exrst) rises.push_back(i);
      prev_exrst = rx_exrst;
      if (link_up) nlu++;
    end
    nr = rises.size();
    chk("nl_rises", nr, 3);
    if (nr >= 1) chk("nl_first", rises[0], RXR + LW);
    if (nr >= 3) begin
      chk("nl_period1", rises[1] - rises[0], RXR + LW);
      chk("nl_period2", rises[2] - rises[1], RXR + LW);
    end
    chk("nl_err", int'(err_count), 3);
    chk("nl_link", nlu, 0);

    // Saturation via repeated TX lock timeouts, then async reset in TXWAIT
    do_reset();
    wait_state(5, 100, "sat_run");
    tx_lock = 1'b0;
    for (int i = 0; i < 300 * (TXR + LW + 2) && err_count != 8'hFF; i++) step();
    chk("sat_255", int'(err_count), 255);
    repeat (250) step();
    chk("sat_hold", int'(err_count), 255);
    wait_state(4, 200, "sat_txwait");
    #5 rstin = 1'b1;
    #1;
    chk("ar_state", int'(state), 0);
    chk("ar_exrst", int'(rx_exrst), 1);
    chk("ar_txrst", int'(tx_pll_reset), 1);
    chk("ar_src", int'(src_sel), 0);
    chk("ar_link", int'(link_up), 0);
    chk("ar_err", int'(err_count), 0);
    step();
    rstin = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
